// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU and the ALU-control decoder.
//   - alusel codes ({instr[30], funct3}) for the ten legal operations
//   - execution-unit state encoding (IDLE / SHIFT / DONE)
//   - small helpers to classify an alusel code
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  // True for the three ops that run on the serial shifter.
  function automatic logic alu_is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

  // True for any of the ten defined codes.
  function automatic logic alu_is_legal(input logic [3:0] sel);
    logic legal;
    case (sel)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
// Serial one-bit-per-cycle shifter. Owns the shift accumulator and the
// remaining-bit counter; shift direction and fill mode are captured at load.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort, drops any shift in progress
//   load       : capture din/shamt/dir/arith this cycle
//   dir        : 0 = left (SLL), 1 = right (SRL/SRA)
//   arith      : right shifts replicate the sign bit when 1
//   shamt      : number of single-bit steps to perform
//   din        : value to shift
//   busy       : steps remain (counter non-zero)
//   last       : exactly one step remains; dout is the final value
//   dout       : accumulator after one more step (value written next edge)
// -----------------------------------------------------------------------------
module seq_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic               dir,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [XLEN-1:0]    din,
  output logic               busy,
  output logic               last,
  output logic [XLEN-1:0]    dout
);

  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_reg;
  logic               arith_reg;
  logic [XLEN-1:0]    acc_next;

  // One-bit step of the accumulator in the captured direction.
  always_comb begin
    if (dir_reg) begin
      acc_next = {arith_reg & acc[XLEN-1], acc[XLEN-1:1]};
    end else begin
      acc_next = {acc[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      dir_reg   <= 1'b0;
      arith_reg <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      acc       <= din;
      cnt       <= shamt;
      dir_reg   <= dir;
      arith_reg <= arith;
    end else if (cnt != '0) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == SHAMT_W'(1));
  assign dout = acc_next;

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Execution unit between register-read and writeback. Logic, arithmetic and
// compare ops complete in one cycle; shifts run on the serial seq_shifter.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   alusel              : {instr[30], funct3} operation code
//   a, b                : operands; shifts use b[SHAMT_W-1:0]
//   flush               : synchronous abort back to IDLE
//   out_valid/out_ready : result handshake
//   result, zero        : registered result and result==0 flag
//   illegal             : alusel was not a defined code
// -----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alusel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_t         state;
  logic               accept;
  logic               op_shift;
  logic               op_legal;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_result;
  logic               shift_busy;
  logic               shift_last;
  logic [XLEN-1:0]    shift_dout;

  assign in_ready = (state == IDLE);
  // A request that coincides with flush is dropped.
  assign accept   = in_valid && in_ready && !flush;
  assign op_shift = alu_is_shift(alusel);
  assign op_legal = alu_is_legal(alusel);
  assign shamt    = b[SHAMT_W-1:0];

  // Single-cycle datapath. Shift and illegal codes fall through to 0; shifts
  // are produced by the serial shifter instead.
  always_comb begin
    alu_result = '0;
    case (alusel)
      ALU_ADD:  alu_result = a + b;
      ALU_SUB:  alu_result = a - b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  alu_result = a ^ b;
      ALU_OR:   alu_result = a | b;
      ALU_AND:  alu_result = a & b;
      default:  alu_result = '0;
    endcase
  end

  seq_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .load  (accept && op_shift),
    .dir   (alusel != ALU_SLL),
    .arith (alusel == ALU_SRA),
    .shamt (shamt),
    .din   (a),
    .busy  (shift_busy),
    .last  (shift_last),
    .dout  (shift_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      // result/zero/illegal keep whatever they held; only control is aborted.
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_shift) begin
              if (shamt == '0) begin
                // Zero-length shift completes immediately with a unchanged.
                result    <= a;
                zero      <= (a == '0);
                illegal   <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                state <= SHIFT;
              end
            end else begin
              result    <= alu_result;
              zero      <= (alu_result == '0);
              illegal   <= !op_legal;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          if (shift_last) begin
            // Capture the value produced by the final step, on the same edge
            // the shifter's counter reaches zero.
            result    <= shift_dout;
            zero      <= (shift_dout == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (!shift_busy) begin
            // Shifter idle without a final step: recover rather than hang.
            state <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Execution unit that consumes the 4-bit alusel code ({instr[30], funct3}) produced by the ALU-control decoder, plus two XLEN operands, and returns a registered result.
- Logic, arithmetic and compare ops finish in one cycle. Shifts run on a serial one-bit-per-cycle shifter to save area.
- Sits between the decode/register-read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- alusel  input  4  operation code.
- a  input  XLEN  operand 1 (rs1).
- b  input  XLEN  operand 2 (rs2/imm); shifts use b[SHAMT_W-1:0].
- flush  input  1  synchronous abort.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0.
- illegal  output  1  alusel was not a legal code.

Behaviour:
- Reset is asynchronous, active-low, and may arrive at any time, including mid-shift. It forces state IDLE and clears result, zero, illegal, out_valid and the shift counter to 0. in_ready is 1 during and after reset.
- Codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Every other code (1001, 1010, 1011, 1100, 1110, 1111) is illegal: result 0, illegal=1, single-cycle path.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag. SLT/SLTU return 0 or 1, zero-extended.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE).
- Accept: in_valid && in_ready at a rising edge. Operands and alusel are captured only at accept; later input changes are ignored.
- Accepting a non-shift op:
  - result, zero and illegal are registered at the accept edge; state goes to DONE.
  - out_valid is high in the cycle after accept (latency 1).
- Accepting a shift (SLL/SRL/SRA):
  - Load acc=a and cnt=b[SHAMT_W-1:0].
  - cnt==0: result=a, go to DONE (latency 1).
  - Otherwise go to SHIFT. Each cycle shift acc by one bit (SRA replicates acc[XLEN-1]; SLL/SRL fill 0) and decrement cnt. On the edge where cnt goes 1→0, write acc into result and go to DONE.
  - out_valid rises n cycles after accept for shift amount n ≥ 1. Worst case is 31 for XLEN=32.
- DONE:
  - result, zero and illegal are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE; out_valid low next cycle.
  - Minimum issue interval is 2 cycles.
- flush (sync, highest priority after reset): from any state, next state is IDLE and out_valid drops. result and illegal retain their last values, don't-care. A request presented with flush in the same cycle is not accepted.
- zero is derived from the final result, never from intermediate shift values.

Decomposition:
- Package alu_pkg:
  - localparams for all ten legal alusel codes (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND).
  - the state encoding (IDLE/SHIFT/DONE).
  - This package is shared with the ALU-control decoder.
- Sub-module seq_shifter:
  - owns acc and cnt.
  - ports: load, dir, arith, shamt, din, busy, dout.
- seq_alu keeps the FSM, the handshakes and the single-cycle datapath.

Test Plan:
- ADD then SUB, each with out_ready=1:
  - ADD a=0xFFFFFFFF, b=1 → result 0x00000000, zero=1, out_valid exactly 1 cycle after accept.
  - SUB a=5, b=7 → result 0xFFFFFFFE.
- SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0. Both have zero=0, illegal=0.
- SRA a=0x80000000, b=31 → 0xFFFFFFFF, out_valid 31 cycles after accept; in_ready=0 throughout.
  - SRL with the same operands → 0x00000001.
  - SLL a=0x1234, b=0 → 0x1234, latency 1.
- Backpressure: XOR a=0xF0F0F0F0, b=0xFFFFFFFF with out_ready=0 for 5 cycles → out_valid and result 0x0F0F0F0F stable, in_ready=0. out_ready=1 → IDLE next cycle.
- Illegal code alusel=1111, a=3, b=4 → result 0, illegal=1, zero=1, latency 1.
- Aborts:
  - flush on the 3rd cycle of SLL b=10 → IDLE next cycle, out_valid never asserted; a following ADD 2+2 returns 4.
  - rst_n pulsed low mid-shift → outputs clear immediately; in_ready=1.
